// File: rtl/pipe_ctrl_chain_pkg.sv
// Shared defaults, per-stage control layout and helpers for the back-end
// pipeline register chain.
package pipe_ctrl_chain_pkg;

    localparam int unsigned DEF_DEPTH    = 3;
    localparam int unsigned DEF_WIDTH    = 64;
    localparam int unsigned DEF_REG_BITS = 4;
    localparam int unsigned CNT_W        = 16;

    // Control bits carried alongside every stage payload
    typedef struct packed {
        logic valid;
        logic wb;
        logic mrd;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_BUBBLE = '0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/pipe_ctrl_chain_stage.sv
// One pipeline stage register: holds when en=0, loads a zeroed bubble or the
// upstream fields when en=1.
module pipe_stage_slot
    import pipe_ctrl_chain_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned REG_BITS = DEF_REG_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                load_bubble,
    input  stage_ctrl_t         d_ctrl,
    input  logic [REG_BITS-1:0] d_dest,
    input  logic [WIDTH-1:0]    d_payload,
    output stage_ctrl_t         q_ctrl,
    output logic [REG_BITS-1:0] q_dest,
    output logic [WIDTH-1:0]    q_payload
);

    stage_ctrl_t         ctrl_q, ctrl_d;
    logic [REG_BITS-1:0] dest_q, dest_d;
    logic [WIDTH-1:0]    payload_q, payload_d;

    // Bubbles clear every field so stage taps never expose stale data
    always_comb begin
        ctrl_d    = ctrl_q;
        dest_d    = dest_q;
        payload_d = payload_q;
        if (en) begin
            if (load_bubble) begin
                ctrl_d    = CTRL_BUBBLE;
                dest_d    = '0;
                payload_d = '0;
            end else begin
                ctrl_d    = d_ctrl;
                dest_d    = d_dest;
                payload_d = d_payload;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q    <= CTRL_BUBBLE;
            dest_q    <= '0;
            payload_q <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            dest_q    <= dest_d;
            payload_q <= payload_d;
        end
    end

    assign q_ctrl    = ctrl_q;
    assign q_dest    = dest_q;
    assign q_payload = payload_q;

endmodule

// File: rtl/pipe_ctrl_chain.sv
// EXE..WB pipeline register chain with bubble insertion, branch squash,
// global hold, RAW hazard detection and a saturating stall counter.
module pipe_ctrl_chain
    import pipe_ctrl_chain_pkg::*;
#(
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned REG_BITS = DEF_REG_BITS,
    parameter int unsigned FWD_EN   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_payload,
    input  logic [REG_BITS-1:0]    in_dest,
    input  logic                   in_wb_en,
    input  logic                   in_mem_r_en,
    input  logic [REG_BITS-1:0]    in_src1,
    input  logic [REG_BITS-1:0]    in_src2,
    input  logic                   in_two_src,
    input  logic                   branch_taken,
    input  logic                   hold,
    output logic                   hazard,
    output logic                   freeze_up,
    output logic [DEPTH-1:0]       stage_valid,
    output logic [DEPTH*WIDTH-1:0] stage_payload,
    output logic                   out_valid,
    output logic                   out_wb_en,
    output logic [REG_BITS-1:0]    out_dest,
    output logic [CNT_W-1:0]       hazard_cnt
);

    stage_ctrl_t         ctrl_q    [DEPTH];
    logic [REG_BITS-1:0] dest_q    [DEPTH];
    logic [WIDTH-1:0]    payload_q [DEPTH];

    stage_ctrl_t      in_ctrl;
    logic             stage_en;
    logic             bubble0;
    logic [DEPTH-1:0] chk;
    logic [DEPTH-1:0] m1;
    logic [DEPTH-1:0] m2;
    logic             raw;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign in_ctrl  = '{valid: in_valid, wb: in_wb_en, mrd: in_mem_r_en};
    assign stage_en = !hold;
    assign bubble0  = branch_taken | hazard | !in_valid;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            pipe_stage_slot #(.WIDTH(WIDTH), .REG_BITS(REG_BITS)) u_slot (
                .clk        (clk),
                .rst        (rst),
                .en         (stage_en),
                .load_bubble(bubble0),
                .d_ctrl     (in_ctrl),
                .d_dest     (in_dest),
                .d_payload  (in_payload),
                .q_ctrl     (ctrl_q[k]),
                .q_dest     (dest_q[k]),
                .q_payload  (payload_q[k])
            );
        end else begin : g_body
            pipe_stage_slot #(.WIDTH(WIDTH), .REG_BITS(REG_BITS)) u_slot (
                .clk        (clk),
                .rst        (rst),
                .en         (stage_en),
                .load_bubble(1'b0),
                .d_ctrl     (ctrl_q[k-1]),
                .d_dest     (dest_q[k-1]),
                .d_payload  (payload_q[k-1]),
                .q_ctrl     (ctrl_q[k]),
                .q_dest     (dest_q[k]),
                .q_payload  (payload_q[k])
            );
        end

        assign stage_valid[k]                 = ctrl_q[k].valid;
        assign stage_payload[k*WIDTH +: WIDTH] = payload_q[k];
        assign m1[k] = (dest_q[k] == in_src1);
        assign m2[k] = (dest_q[k] == in_src2);

        // WB stage is write-through, so it never produces a hazard
        if (k == DEPTH - 1) begin : g_chk_wb
            assign chk[k] = 1'b0;
        end else if (FWD_EN == 0) begin : g_chk_all
            assign chk[k] = ctrl_q[k].valid & ctrl_q[k].wb;
        end else if (k == 0) begin : g_chk_load
            assign chk[k] = ctrl_q[k].valid & ctrl_q[k].wb & ctrl_q[k].mrd;
        end else begin : g_chk_fwd
            assign chk[k] = 1'b0;
        end
    end

    assign raw       = in_valid & ((|(chk & m1)) | (in_two_src & (|(chk & m2))));
    assign hazard    = raw & !branch_taken & !hold;
    assign freeze_up = hazard | hold;

    // Stall-cycle counter; hazard is already masked by hold
    always_comb begin
        cnt_d = cnt_q;
        if (hazard) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hazard_cnt = cnt_q;
    assign out_valid  = ctrl_q[DEPTH-1].valid;
    assign out_wb_en  = ctrl_q[DEPTH-1].valid & ctrl_q[DEPTH-1].wb;
    assign out_dest   = dest_q[DEPTH-1];

endmodule
